// File: rtl/program_store.sv
// rtl/program_store.sv - 16x8 program memory with byte-wide loader and CPU hold control.
// Optional checksum byte and ERROR state when PROGRAM_CHECKSUM_EN is defined.
module program_store #(
  parameter logic [7:0] IDLE_INST = 8'h00
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic [3:0] pc,
  output logic [7:0] inst,
  output logic       cpu_hold,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       ld_error
);

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
`ifdef PROGRAM_CHECKSUM_EN
  localparam logic [1:0] S_ERROR = 2'd3;
`endif

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] mem_q [16];
  logic       accept;
  logic       wr_en;
`ifdef PROGRAM_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_chk;
`endif

  // A restart in LOAD takes priority over a byte offered in the same cycle.
  assign accept = (state_q == S_LOAD) && ld_valid && !ld_start;

`ifdef PROGRAM_CHECKSUM_EN
  assign sum_chk = sum_q + ld_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
`ifdef PROGRAM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (ld_start) begin
      state_d = S_LOAD;
      cnt_d   = 5'd0;
`ifdef PROGRAM_CHECKSUM_EN
      sum_d   = 8'h00;
`endif
    end else if (accept) begin
      cnt_d = cnt_q + 5'd1;
`ifdef PROGRAM_CHECKSUM_EN
      // The 17th byte is the checksum and never touches mem.
      if (cnt_q == 5'd16) begin
        state_d = (sum_chk == 8'h00) ? S_RUN : S_ERROR;
      end else begin
        wr_en = 1'b1;
        sum_d = sum_chk;
      end
`else
      wr_en = 1'b1;
      if (cnt_q == 5'd15) begin
        state_d = S_RUN;
      end
`endif
    end
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q <= S_HALT;
      cnt_q   <= 5'd0;
`ifdef PROGRAM_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PROGRAM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
      if (wr_en) begin
        mem_q[cnt_q[3:0]] <= ld_data;
      end
    end
  end

  assign ld_ready = (state_q == S_LOAD);
  assign ld_done  = (state_q == S_RUN);
  assign cpu_hold = (state_q != S_RUN);
  assign inst     = (state_q == S_RUN) ? mem_q[pc] : IDLE_INST;
`ifdef PROGRAM_CHECKSUM_EN
  assign ld_error = (state_q == S_ERROR);
`else
  assign ld_error = 1'b0;
`endif

endmodule

// File: tb/tb_program_store.sv
// tb/tb_program_store.sv - self-checking bench for program_store.
module tb_program_store;

  logic       clk_cpu;
  logic       reset;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       cpu_hold;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       ld_error;

  program_store dut (
    .clk_cpu  (clk_cpu),
    .reset    (reset),
    .pc       (pc),
    .inst     (inst),
    .cpu_hold (cpu_hold),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_error (ld_error)
  );

  typedef struct {
    logic [3:0] pc;
    logic [7:0] inst;
    logic       hold;
    logic       ready;
    logic       done;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] sb [$];

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic apply_vecs(input vec_t v [], input string tag);
    for (int k = 0; k < v.size(); k++) begin
      pc = v[k].pc;
      #1;
      chk({tag, "_inst"},  inst,     v[k].inst);
      chk({tag, "_hold"},  cpu_hold, v[k].hold);
      chk({tag, "_ready"}, ld_ready, v[k].ready);
      chk({tag, "_done"},  ld_done,  v[k].done);
      chk({tag, "_error"}, ld_error, 1'b0);
    end
  endtask

  // Loads base, base+1, ... ; optional every-other-cycle valid and one mid-load restart.
  task automatic do_load(input logic [7:0] base, input bit toggle, input int restart_at);
    int  i;
    int  cyc;
    bit  v;
    bit  restarted;
    logic [7:0] sum;
    i = 0; cyc = 0; restarted = 0;
    pc = 4'd0;
    ld_start = 1'b1; ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    chk("start_ready", ld_ready, 1'b1);
    chk("start_hold",  cpu_hold, 1'b1);
    chk("start_inst",  inst,     8'h00);
    chk("start_done",  ld_done,  1'b0);
    sb.delete();
    while (i < 16 && cyc < 200) begin
      if (i == restart_at && !restarted) begin
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        restarted = 1; i = 0; sb.delete(); cyc++;
        chk("restart_ready", ld_ready, 1'b1);
        chk("restart_hold",  cpu_hold, 1'b1);
        continue;
      end
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      ld_valid = v;
      ld_data  = base + 8'(i);
      tick();
      cyc++;
      if (v) begin
        sb.push_back(base + 8'(i));
        i++;
      end
`ifdef PROGRAM_CHECKSUM_EN
      chk("load_ready", ld_ready, 1'b1);
      chk("load_hold",  cpu_hold, 1'b1);
`else
      if (i < 16) begin
        chk("load_ready", ld_ready, 1'b1);
        chk("load_hold",  cpu_hold, 1'b1);
      end
`endif
    end
    if (cyc >= 200) chk("load_budget", 8'(cyc), 8'(0));
`ifdef PROGRAM_CHECKSUM_EN
    sum = 8'h00;
    for (int k = 0; k < 16; k++) sum = sum + base + 8'(k);
    ld_valid = 1'b1; ld_data = 8'h00 - sum;
    tick();
`else
    sum = 8'h00;
`endif
    ld_valid = 1'b0;
    chk("end_hold",  cpu_hold, 1'b0);
    chk("end_done",  ld_done,  1'b1);
    chk("end_ready", ld_ready, 1'b0);
    chk("end_error", ld_error, sum[0] & 1'b0);
  endtask

  task automatic verify_mem();
    logic [7:0] exp;
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 8'(p), 8'hFF);
      end else begin
        exp = sb.pop_front();
        chk("mem_inst", inst, exp);
      end
    end
    chk("sb_left", 8'(sb.size()), 8'd0);
  endtask

`ifdef PROGRAM_CHECKSUM_EN
  task automatic cs_load(input logic [7:0] cs, input bit good);
    ld_start = 1'b1; ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    chk("cs_start_error", ld_error, 1'b0);
    chk("cs_start_ready", ld_ready, 1'b1);
    for (int k = 0; k < 17; k++) begin
      ld_valid = 1'b1;
      ld_data  = (k == 16) ? cs : 8'h01;
      tick();
    end
    ld_valid = 1'b0;
    pc = 4'd4;
    #1;
    chk("cs_error", ld_error, !good);
    chk("cs_hold",  cpu_hold, !good);
    chk("cs_done",  ld_done,  good);
    chk("cs_inst",  inst,     good ? 8'h01 : 8'h00);
  endtask
`endif

  initial begin
    vec_t reset_vec [];
    vec_t run_vec [];
    reset_vec = new[3];
    reset_vec[0] = '{4'd0,  8'h00, 1'b1, 1'b0, 1'b0};
    reset_vec[1] = '{4'd7,  8'h00, 1'b1, 1'b0, 1'b0};
    reset_vec[2] = '{4'd15, 8'h00, 1'b1, 1'b0, 1'b0};
    run_vec = new[4];
    run_vec[0] = '{4'd5,  8'h35, 1'b0, 1'b0, 1'b1};
    run_vec[1] = '{4'd15, 8'h3F, 1'b0, 1'b0, 1'b1};
    run_vec[2] = '{4'd0,  8'h30, 1'b0, 1'b0, 1'b1};
    run_vec[3] = '{4'd10, 8'h3A, 1'b0, 1'b0, 1'b1};

    reset = 1'b0; pc = 4'd0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    tick();
    apply_vecs(reset_vec, "rst_low");
    reset = 1'b1;
    tick();
    tick();
    apply_vecs(reset_vec, "rst_rel");

    do_load(8'h30, 1'b0, -1);
    apply_vecs(run_vec, "run");
    verify_mem();

    do_load(8'h80, 1'b1, 7);
    verify_mem();

    do_load(8'hC4, 1'b0, -1);
    verify_mem();

    // Asynchronous reset mid-run.
    reset = 1'b0;
    #1;
    apply_vecs(reset_vec, "mid_rst");
    tick();
    reset = 1'b1;
    tick();
    apply_vecs(reset_vec, "post_rst");
    do_load(8'h10, 1'b1, -1);
    pc = 4'd3;
    #1;
    chk("reload_mem3", inst, 8'h13);
    verify_mem();

`ifdef PROGRAM_CHECKSUM_EN
    cs_load(8'hF0, 1'b1);
    cs_load(8'hF1, 1'b0);
    tick();
    chk("err_sticky", ld_error, 1'b1);
    do_load(8'h21, 1'b0, -1);
    verify_mem();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
